// File: rtl/conv3x3_frame_sequencer.sv
// Frame sequencer for the 3x3 systolic convolution datapath.
// Walks the frame in bands of three rows, one column per cycle. Each column
// read is tagged, and each tag is matched to the conv result it produces.
// Only fully populated windows reach the output stream.
module conv3x3_frame_sequencer #(
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 24,
    parameter int DIM_W     = 6,
    parameter int ADDR_W    = 12,
    parameter int TAG_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  img_w,
    input  logic [DIM_W-1:0]  img_h,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr0,
    output logic [ADDR_W-1:0] mem_rd_addr1,
    output logic [ADDR_W-1:0] mem_rd_addr2,
    input  logic [DATA_W-1:0] mem_rd_data0,
    input  logic [DATA_W-1:0] mem_rd_data1,
    input  logic [DATA_W-1:0] mem_rd_data2,
    output logic              conv_in_valid,
    output logic [DATA_W-1:0] conv_px0,
    output logic [DATA_W-1:0] conv_px1,
    output logic [DATA_W-1:0] conv_px2,
    input  logic              conv_out_valid,
    input  logic [ACC_W-1:0]  conv_out_pixel,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_pixel,
    output logic [DIM_W-1:0]  out_x,
    output logic [DIM_W-1:0]  out_y,
    output logic              tag_err
);

    localparam int TAG_W = 1 + 2 * DIM_W;
    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = $clog2(TAG_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(TAG_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [DIM_W-1:0]   w_q, w_d, h_q, h_d, r_q, r_d, c_q, c_d;
    logic [ADDR_W-1:0]  base0_q, base0_d, base1_q, base1_d, base2_q, base2_d;
    logic               cfg_err_q, cfg_err_d;

    logic               rd_vld_q, in_valid_q;
    logic [TAG_W-1:0]   rd_tag_q, push_tag_q;
    logic [DATA_W-1:0]  px0_q, px1_q, px2_q;

    logic [TAG_W-1:0]   tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               fifo_empty, fifo_full, do_push, do_pop;
    logic [TAG_W-1:0]   head_tag;

    logic               tag_err_q, out_valid_q;
    logic [ACC_W-1:0]   out_pixel_q;
    logic [DIM_W-1:0]   out_x_q, out_y_q;

    logic               issue, last_col;
    logic [ADDR_W-1:0]  c_ext, w_ext;

    assign issue    = (state_q == ISSUE);
    assign last_col = (c_q == w_q - DIM_W'(1));
    assign c_ext    = ADDR_W'(c_q);
    assign w_ext    = ADDR_W'(w_q);

    assign busy          = (state_q == ISSUE) || (state_q == DRAIN);
    assign done          = (state_q == DONE);
    assign cfg_err       = cfg_err_q;
    assign mem_rd_en     = issue;
    assign mem_rd_addr0  = issue ? base0_q + c_ext : '0;
    assign mem_rd_addr1  = issue ? base1_q + c_ext : '0;
    assign mem_rd_addr2  = issue ? base2_q + c_ext : '0;
    assign conv_in_valid = in_valid_q;
    assign conv_px0      = px0_q;
    assign conv_px1      = px1_q;
    assign conv_px2      = px2_q;
    assign out_valid     = out_valid_q;
    assign out_pixel     = out_pixel_q;
    assign out_x         = out_x_q;
    assign out_y         = out_y_q;
    assign tag_err       = tag_err_q;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign do_push    = in_valid_q && !fifo_full;
    assign do_pop     = conv_out_valid && !fifo_empty;
    assign head_tag   = tag_mem[rd_ptr_q];

    // Frame control: accept/reject start, walk columns and bands, drain, finish
    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        h_d       = h_q;
        r_d       = r_q;
        c_d       = c_q;
        base0_d   = base0_q;
        base1_d   = base1_q;
        base2_d   = base2_q;
        cfg_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (img_w >= DIM_W'(3) && img_h >= DIM_W'(3)) begin
                        w_d     = img_w;
                        h_d     = img_h;
                        r_d     = '0;
                        c_d     = '0;
                        base0_d = '0;
                        base1_d = ADDR_W'(img_w);
                        base2_d = ADDR_W'(img_w) + ADDR_W'(img_w);
                        state_d = ISSUE;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (last_col) begin
                    c_d = '0;
                    if (r_q == h_q - DIM_W'(3)) begin
                        state_d = DRAIN;
                    end else begin
                        r_d     = r_q + DIM_W'(1);
                        base0_d = base0_q + w_ext;
                        base1_d = base1_q + w_ext;
                        base2_d = base2_q + w_ext;
                    end
                end else begin
                    c_d = c_q + DIM_W'(1);
                end
            end
            DRAIN: begin
                if (fifo_empty && !rd_vld_q && !in_valid_q && !conv_out_valid) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            w_q       <= '0;
            h_q       <= '0;
            r_q       <= '0;
            c_q       <= '0;
            base0_q   <= '0;
            base1_q   <= '0;
            base2_q   <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            w_q       <= w_d;
            h_q       <= h_d;
            r_q       <= r_d;
            c_q       <= c_d;
            base0_q   <= base0_d;
            base1_q   <= base1_d;
            base2_q   <= base2_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Issue pipeline: the tag and valid ride through the memory return stage
    // so they line up with the registered pixels presented to the conv
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q   <= 1'b0;
            rd_tag_q   <= '0;
            in_valid_q <= 1'b0;
            push_tag_q <= '0;
            px0_q      <= '0;
            px1_q      <= '0;
            px2_q      <= '0;
        end else begin
            rd_vld_q   <= issue;
            rd_tag_q   <= {(c_q >= DIM_W'(2)), c_q - DIM_W'(2), r_q};
            in_valid_q <= rd_vld_q;
            push_tag_q <= rd_tag_q;
            px0_q      <= mem_rd_data0;
            px1_q      <= mem_rd_data1;
            px2_q      <= mem_rd_data2;
        end
    end

    // Tag storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) begin
            tag_mem[wr_ptr_q] <= push_tag_q;
        end
    end

    // Tag FIFO pointers, occupancy and sticky protocol error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            tag_err_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if ((conv_out_valid && fifo_empty) || (in_valid_q && fifo_full)) begin
                tag_err_q <= 1'b1;
            end
        end
    end

    // Result matching: a popped tag with keep set becomes a coordinate-tagged output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_pixel_q <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
        end else begin
            out_valid_q <= do_pop && head_tag[TAG_W-1];
            if (do_pop && head_tag[TAG_W-1]) begin
                out_pixel_q <= conv_out_pixel;
                out_x_q     <= head_tag[2*DIM_W-1:DIM_W];
                out_y_q     <= head_tag[DIM_W-1:0];
            end
        end
    end

endmodule
